fetch_sequencer: RTL

Instruction-fetch controller between the combinational instruction memory and the decode stage of the floating-point DSP pipeline. It owns the program counter, drives the memory address, and buffers fetched words in a small FIFO. Fetched words go to decode over a valid/ready handshake. It also applies branch/jump redirects with a queue flush and supports run/idle control from the top level.

---
 rtl/dsp_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 83 ++++++++
 rtl/fetch_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// ============================================================================
// dsp_pkg : shared types and constants for the DSP fetch front end
// Rev 1.0
// ============================================================================
`default_nettype none

package dsp_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : circular {instr, pc} FIFO with push, pop, flush and count
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue
    import dsp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [31:0]             push_instr,
    input  logic [PC_W-1:0]         push_pc,
    input  logic                    pop,
    input  logic                    flush,
    output logic [31:0]             head_instr,
    output logic [PC_W-1:0]         head_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t         mem_q [DEPTH];
    fq_entry_t         mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              w_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        w_pop    = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: push_instr, pc: push_pc};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head is read straight from storage so back-to-back pops need no bubble.
    assign head_instr = mem_q[rd_ptr_q].instr;
    assign head_pc    = mem_q[rd_ptr_q].pc;
    assign count      = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer : PC, run/idle FSM and redirect control feeding decode
// Optional macro FETCH_HALT_EN adds a terminal HALT state on the all-ones word.
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
    import dsp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_instr,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       id_valid,
    output logic [31:0]                id_instr,
    output logic [31:0]                id_pc,
    input  logic                       id_ready,
    output logic [$clog2(FQ_DEPTH):0]  fq_count,
    output logic [1:0]                 state_o
);

    localparam int                CW       = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0]     FULL_CNT = CW'(FQ_DEPTH);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             w_pop, w_full, w_redirect, w_fetch;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

    always_comb begin
        w_pop      = id_valid && id_ready;
        w_full     = (fq_count == FULL_CNT);
        w_redirect = redirect_valid && (state_q != ST_HALT);
        // A full queue may still fetch when its head leaves this same cycle.
        w_fetch    = (state_q == ST_RUN) && fetch_en && !w_redirect && (!w_full || w_pop);
        pc_d       = pc_q;
        if (w_redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (w_fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fetch_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!fetch_en) begin
                    state_d = ST_IDLE;
                end
`ifdef FETCH_HALT_EN
                else if (w_fetch && (imem_instr == HALT_WORD)) begin
                    state_d = ST_HALT;
                end
`endif
            end
`ifdef FETCH_HALT_EN
            ST_HALT: state_d = ST_HALT;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_addr = pc_q;
        state_o   = state_q;
        id_valid  = (fq_count != '0);
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (w_fetch),
        .push_instr (imem_instr),
        .push_pc    (pc_q),
        .pop        (w_pop),
        .flush      (w_redirect),
        .head_instr (id_instr),
        .head_pc    (id_pc),
        .count      (fq_count)
    );

endmodule

`default_nettype wire
